// File: rtl/occ_pkg.sv
// Shared types for the multi-zone occupancy timer: zone state encoding and
// the width of the occupied-zone count.
package occ_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    OCCUPIED = 2'd1,
    COUNTING = 2'd2,
    WARNING  = 2'd3
  } zone_state_e;

  function automatic int zone_cnt_w(input int n_zones);
    return $clog2(n_zones + 1);
  endfunction

endpackage

// File: rtl/occ_debounce.sv
// Presence input conditioning: 2-FF synchroniser followed by a stable-count
// filter that accepts a new level only after DEB_T consecutive differing cycles.
module occ_debounce #(
  parameter int DEB_T = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int DW = (DEB_T > 1) ? $clog2(DEB_T) : 1;

  logic          sync1, sync2;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any return to the accepted level restarts the qualification window.
      if (sync2 == dout) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DW'(DEB_T - 1)) begin
        dout       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/occupancy_timer_multi.sv
// Multi-zone occupancy timer: per-zone debounce, occupancy FSM and absence
// counter, plus a registered occupied-zone count. OCC_WARN_EN adds a warning stage.
//
// state    | meaning
// OFF      | light off, waiting for presence on an enabled zone
// OCCUPIED | presence seen, counter held at 0
// COUNTING | absence, counter running toward shutdown
// WARNING  | late absence, warn asserted (OCC_WARN_EN builds only)
module occupancy_timer_multi
  import occ_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int CNT_W      = 16,
  parameter int SHUTDOWN_T = 30000,
  parameter int WARN_T     = 25000,
  parameter int DEB_T      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_ZONES-1:0]                  presence,
  input  logic [N_ZONES-1:0]                  zone_en,
  output logic [N_ZONES-1:0]                  light_on,
  output logic [N_ZONES-1:0]                  shutdown_pulse,
  output logic [N_ZONES-1:0]                  warn,
  output logic [zone_cnt_w(N_ZONES)-1:0]      zones_on
);

  localparam int ZW = zone_cnt_w(N_ZONES);

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    logic             p;
    zone_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             expire;
    logic             light_q, pulse_q;

    occ_debounce #(.DEB_T(DEB_T)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (presence[z]),
      .dout (p)
    );

    always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      expire    = 1'b0;
      if (!zone_en[z]) begin
        state_nxt = OFF;
      end else begin
        unique case (state)
          OFF:      if (p) state_nxt = OCCUPIED;
          OCCUPIED: if (!p) state_nxt = COUNTING;
          COUNTING, WARNING: begin
            // Presence wins over a timeout landing on the same cycle.
            if (p) begin
              state_nxt = OCCUPIED;
            end else if (cnt == CNT_W'(SHUTDOWN_T - 1)) begin
              state_nxt = OFF;
              expire    = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
`ifdef OCC_WARN_EN
              if (state == COUNTING && cnt == CNT_W'(WARN_T - 1)) state_nxt = WARNING;
`endif
            end
          end
          default: state_nxt = OFF;
        endcase
      end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register and the pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= OFF;
        cnt     <= '0;
        light_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        light_q <= (state_nxt != OFF);
        pulse_q <= expire;
      end
    end

    assign light_on[z]       = light_q;
    assign shutdown_pulse[z] = pulse_q;

`ifdef OCC_WARN_EN
    logic warn_q;
    always_ff @(posedge clk) begin
      if (rst) warn_q <= 1'b0;
      else     warn_q <= (state_nxt == WARNING);
    end
    assign warn[z] = warn_q;
`else
    assign warn[z] = 1'b0;
`endif
  end

  logic [ZW-1:0] occ_cnt;

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < N_ZONES; i++) occ_cnt = occ_cnt + ZW'(light_on[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) zones_on <= '0;
    else     zones_on <= occ_cnt;
  end

endmodule
